// File: rtl/tick_meter_pkg.sv
// ============================================================================
//  Package     : tick_meter_pkg
//  Description : Shared types and sizing helpers for the tick rate meter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned C_GATE_CYCLES_DEF = 1024;
    localparam int unsigned C_CNT_W_DEF       = 16;

    // Timer must index 0..cycles-1; a single bit is the floor for tiny windows.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_edge_detect.sv
// ============================================================================
//  Module      : tick_edge_detect
//  Description : Rising-edge detector for a clk-synchronous divider output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic edge_pulse
);

    logic r_prev;

    // Previous level resets high so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= sig_in;
        end
    end

    assign edge_pulse = sig_in & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/tick_rate_meter.sv
// ============================================================================
//  Module      : tick_rate_meter
//  Description : Counts divider tick edges over a fixed gate window and hands
//                the result out with valid/ack; also emits a tick square wave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_rate_meter
    import tick_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = C_GATE_CYCLES_DEF,
    parameter int unsigned CNT_W       = C_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick_in,
    input  logic             count_ack,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow,
    output logic             gate_active,
    output logic             square_out
);

    localparam int unsigned      TMR_W  = timer_width(GATE_CYCLES);
    localparam logic [TMR_W-1:0] C_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_SAT  = {CNT_W{1'b1}};

    state_t             r_state;
    state_t             w_next;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf_acc;
    logic               r_ovf;
    logic               r_valid;
    logic               r_square;

    logic               w_edge;
    logic               w_acc_sat;
    logic [CNT_W-1:0]   w_acc_inc;
    logic               w_ovf_inc;
    logic               w_last;
    logic               w_end;
    logic               w_ack;
    logic               w_gate;

    tick_edge_detect u_edge (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (tick_in),
        .edge_pulse (w_edge)
    );

    assign w_acc_sat = (r_acc == C_SAT);
    assign w_acc_inc = (w_edge && !w_acc_sat) ? (r_acc + CNT_W'(1)) : r_acc;
    assign w_ovf_inc = r_ovf_acc | (w_edge & w_acc_sat);
    assign w_last    = (r_timer == C_LAST);
    // An en drop on the final gate cycle aborts rather than publishing.
    assign w_end     = (r_state == GATE) && en && w_last;
    assign w_ack     = r_valid && count_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_gate = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_next = GATE;
                end
            end
            GATE: begin
                w_gate = 1'b1;
                if (!en) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                if (!r_valid || count_ack) begin
                    w_next = en ? GATE : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer   <= '0;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
            r_square  <= 1'b0;
        end else begin
            r_square <= r_square ^ w_edge;

            // Outside GATE the window state is held cleared, ready for entry.
            if (r_state == GATE) begin
                r_timer   <= r_timer + TMR_W'(1);
                r_acc     <= w_acc_inc;
                r_ovf_acc <= w_ovf_inc;
            end else begin
                r_timer   <= '0;
                r_acc     <= '0;
                r_ovf_acc <= 1'b0;
            end

            if (w_end) begin
                r_count <= w_acc_inc;
                r_ovf   <= w_ovf_inc;
                r_valid <= 1'b1;
            end else if (w_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign count_out   = r_count;
    assign count_valid = r_valid;
    assign overflow    = r_ovf;
    assign gate_active = w_gate;
    assign square_out  = r_square;

endmodule

`default_nettype wire

// File: tb/tb_tick_rate_meter.sv
// ============================================================================
//  Module      : tb_tick_rate_meter
//  Description : Directed self-checking bench; 8-bit and 5-bit meters in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_rate_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       tick_in;
    logic       count_ack;

    logic [7:0] cnt8;
    logic       v8, o8, g8, s8;
    logic [4:0] cnt5;
    logic       v5, o5, g5, s5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tick_rate_meter #(.GATE_CYCLES(100), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .tick_in(tick_in), .count_ack(count_ack),
        .count_out(cnt8), .count_valid(v8), .overflow(o8), .gate_active(g8), .square_out(s8)
    );

    tick_rate_meter #(.GATE_CYCLES(100), .CNT_W(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .tick_in(tick_in), .count_ack(count_ack),
        .count_out(cnt5), .count_valid(v5), .overflow(o5), .gate_active(g5), .square_out(s5)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic tick_lvl);
        rst = 1'b1; en = 1'b0; tick_in = tick_lvl; count_ack = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // pat: 0 = pulse every 4, 1 = toggle, 2 = high first 10, 3 = always high, else low
    task automatic run_window(input int pat, input int i0, input int n);
        for (int i = i0; i < i0 + n; i++) begin
            case (pat)
                0:       tick_in = (i % 4 == 0);
                1:       tick_in = (i % 2 == 0);
                2:       tick_in = (i < 10);
                3:       tick_in = 1'b1;
                default: tick_in = 1'b0;
            endcase
            step(1);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        step(3);
        n_tests++; if ({cnt8, v8, o8, g8, s8} !== 12'h000) begin n_fail++; $display("FAIL reset_dut8 got %h exp 000", {cnt8, v8, o8, g8, s8}); end
        n_tests++; if ({cnt5, v5, o5, g5, s5} !== 9'h000) begin n_fail++; $display("FAIL reset_dut5 got %h exp 000", {cnt5, v5, o5, g5, s5}); end
    endtask

    task automatic test_basic_window();
        do_reset(1'b0);
        en = 1'b1;
        step(1);
        n_tests++; if (g8 !== 1'b1) begin n_fail++; $display("FAIL basic_gate_start got %b exp 1", g8); end
        run_window(0, 0, 1);
        n_tests++; if (s8 !== 1'b1) begin n_fail++; $display("FAIL basic_square_rise got %b exp 1", s8); end
        run_window(0, 1, 3);
        n_tests++; if (s8 !== 1'b1) begin n_fail++; $display("FAIL basic_square_high got %b exp 1", s8); end
        run_window(0, 4, 1);
        n_tests++; if (s8 !== 1'b0) begin n_fail++; $display("FAIL basic_square_fall got %b exp 0", s8); end
        run_window(0, 5, 94);
        n_tests++; if ({v8, g8} !== 2'b01) begin n_fail++; $display("FAIL basic_pre_end got v=%b g=%b exp v=0 g=1", v8, g8); end
        run_window(0, 99, 1);
        n_tests++; if ({v8, g8} !== 2'b10) begin n_fail++; $display("FAIL basic_end got v=%b g=%b exp v=1 g=0", v8, g8); end
        n_tests++; if ({cnt8, o8} !== {8'd25, 1'b0}) begin n_fail++; $display("FAIL basic_count8 got %0d ovf %b exp 25 ovf 0", cnt8, o8); end
        n_tests++; if ({cnt5, o5, v5} !== {5'd25, 1'b0, 1'b1}) begin n_fail++; $display("FAIL basic_count5 got %0d ovf %b v %b exp 25 0 1", cnt5, o5, v5); end
    endtask

    task automatic test_held_high();
        do_reset(1'b1);
        en = 1'b1;
        step(1);
        run_window(3, 0, 100);
        tick_in = 1'b0;
        n_tests++; if ({v8, cnt8, s8} !== {1'b1, 8'd0, 1'b0}) begin n_fail++; $display("FAIL held_thru_rst got v=%b cnt=%0d sq=%b exp 1 0 0", v8, cnt8, s8); end
        do_reset(1'b0);
        en = 1'b1;
        step(1);
        run_window(2, 0, 100);
        n_tests++; if ({v8, cnt8, s8} !== {1'b1, 8'd1, 1'b1}) begin n_fail++; $display("FAIL held_level got v=%b cnt=%0d sq=%b exp 1 1 1", v8, cnt8, s8); end
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        en = 1'b1;
        step(1);
        run_window(1, 0, 100);
        n_tests++; if ({cnt8, o8} !== {8'd50, 1'b0}) begin n_fail++; $display("FAIL ovf_count8 got %0d ovf %b exp 50 0", cnt8, o8); end
        n_tests++; if ({cnt5, o5, v5} !== {5'd31, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ovf_count5 got %0d ovf %b v %b exp 31 1 1", cnt5, o5, v5); end
        count_ack = 1'b1; tick_in = 1'b0;
        step(1);
        count_ack = 1'b0;
        n_tests++; if ({v5, g5} !== 2'b01) begin n_fail++; $display("FAIL ovf_b2b_hold got v=%b g=%b exp 0 1", v5, g5); end
        run_window(0, 0, 100);
        n_tests++; if ({cnt5, o5, v5} !== {5'd25, 1'b0, 1'b1}) begin n_fail++; $display("FAIL ovf_clear5 got %0d ovf %b v %b exp 25 0 1", cnt5, o5, v5); end
    endtask

    task automatic test_hold_no_ack();
        do_reset(1'b0);
        en = 1'b1;
        step(1);
        run_window(0, 0, 100);
        run_window(1, 0, 50);
        tick_in = 1'b0;
        n_tests++; if ({v8, g8, cnt8} !== {1'b1, 1'b0, 8'd25}) begin n_fail++; $display("FAIL hold_stable got v=%b g=%b cnt=%0d exp 1 0 25", v8, g8, cnt8); end
        count_ack = 1'b1;
        step(1);
        count_ack = 1'b0;
        n_tests++; if ({v8, g8} !== 2'b01) begin n_fail++; $display("FAIL hold_ack got v=%b g=%b exp 0 1", v8, g8); end
        run_window(4, 0, 100);
        n_tests++; if ({v8, cnt8} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL hold_no_leak got v=%b cnt=%0d exp 1 0", v8, cnt8); end
    endtask

    task automatic test_abort();
        do_reset(1'b0);
        en = 1'b1;
        step(1);
        run_window(0, 0, 100);
        count_ack = 1'b1;
        step(1);
        count_ack = 1'b0;
        run_window(1, 0, 40);
        en = 1'b0; tick_in = 1'b0;
        step(1);
        n_tests++; if ({g8, v8, cnt8} !== {1'b0, 1'b0, 8'd25}) begin n_fail++; $display("FAIL abort_next got g=%b v=%b cnt=%0d exp 0 0 25", g8, v8, cnt8); end
        step(5);
        n_tests++; if ({g8, v8} !== 2'b00) begin n_fail++; $display("FAIL abort_idle got g=%b v=%b exp 0 0", g8, v8); end
    endtask

    task automatic test_rst_mid();
        do_reset(1'b0);
        en = 1'b1;
        step(1);
        run_window(0, 0, 100);
        count_ack = 1'b1;
        step(1);
        count_ack = 1'b0;
        run_window(0, 0, 60);
        rst = 1'b1; tick_in = 1'b0;
        step(1);
        n_tests++; if ({cnt8, v8, o8, g8, s8} !== 12'h000) begin n_fail++; $display("FAIL rst_mid got %h exp 000", {cnt8, v8, o8, g8, s8}); end
        rst = 1'b0;
        step(1);
        n_tests++; if (g8 !== 1'b1) begin n_fail++; $display("FAIL rst_regate got %b exp 1", g8); end
        run_window(0, 0, 99);
        n_tests++; if (v8 !== 1'b0) begin n_fail++; $display("FAIL rst_full_len got v=%b exp 0", v8); end
        run_window(0, 99, 1);
        n_tests++; if ({v8, cnt8} !== {1'b1, 8'd25}) begin n_fail++; $display("FAIL rst_fresh got v=%b cnt=%0d exp 1 25", v8, cnt8); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; tick_in = 1'b0; count_ack = 1'b0;
        test_reset();
        test_basic_window();
        test_held_high();
        test_overflow();
        test_hold_no_ack();
        test_abort();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
